// File: rtl/gfmul_digit.sv
`default_nettype none
// ============================================================================
// Module      : gfmul_digit
// Description : Digit-serial GF(2^128) multiplier for GHASH (GCM bit order:
//               spec bit k = x^k is held at vector bit [127-k], so bit 0 of
//               the polynomial is the MSB of each 128-bit port).
//               Z = X * H mod (x^128 + x^7 + x^2 + x + 1), DIGIT bits of X per
//               clock, 128/DIGIT cycles per product, start/valid handshake.
// Parameters  : DIGIT        bits of X consumed per cycle (must divide 128)
// Macro       : GFMUL_ACC_EN adds iAcc (chain X ^ previous result) and
//               iClear (synchronous zero of result, aborts a running product)
// Ports       : iClk          clock, rising edge
//               iRstn         asynchronous active-low reset
//               iAcc          (GFMUL_ACC_EN) operand becomes iX ^ oResult
//               iClear        (GFMUL_ACC_EN) zero result, return to idle
//               iStart        start request, accepted when oReady=1
//               iX, iH        operands, sampled on an accepted start
//               oReady        idle or done, can accept a start
//               oResult       product Z, held until the next accepted start
//               oResult_valid one-cycle pulse when oResult is final
// Revision    : 1.0 - initial release
// ============================================================================
module gfmul_digit #(
  parameter int DIGIT = 4
) (
  input  logic         iClk,
  input  logic         iRstn,
`ifdef GFMUL_ACC_EN
  input  logic         iAcc,
  input  logic         iClear,
`endif
  input  logic         iStart,
  input  logic [127:0] iX,
  input  logic [127:0] iH,
  output logic         oReady,
  output logic [127:0] oResult,
  output logic         oResult_valid
);

  localparam int c_steps = 128 / DIGIT;
  localparam int c_cnt_w = (c_steps > 1) ? $clog2(c_steps) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_steps - 1);
  // x^128 folds back onto x^7+x^2+x+1, i.e. spec bits 0,1,2,7 -> top byte E1
  localparam logic [127:0] c_red = {8'hE1, 120'd0};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (DIGIT < 1 || (128 % DIGIT) != 0) begin : g_bad_digit
      $error("gfmul_digit: DIGIT=%0d does not divide 128", DIGIT);
    end
  endgenerate

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [127:0]       r_x;
  logic [127:0]       r_v;
  logic [127:0]       r_z;
  logic [c_cnt_w-1:0] r_cnt;
  logic [127:0]       w_z_next;
  logic [127:0]       w_v_next;
  logic [127:0]       w_x_load;
  logic               w_clear;
  logic               w_accept;

`ifdef GFMUL_ACC_EN
  assign w_clear  = iClear;
  assign w_x_load = iAcc ? (iX ^ r_z) : iX;
`else
  assign w_clear  = 1'b0;
  assign w_x_load = iX;
`endif

  assign w_accept = iStart & oReady & ~w_clear;
  assign oResult  = r_z;

  // State register
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = S_RUN;
      S_RUN: begin
        if (w_clear)              w_state_next = S_IDLE;
        else if (r_cnt == c_last) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    oReady        = (r_state == S_IDLE) || (r_state == S_DONE);
    oResult_valid = (r_state == S_DONE);
  end

  // Unrolled chain of DIGIT bit-steps. r_x is shifted left each cycle so the
  // current digit always sits in the top DIGIT bits, which replaces indexing
  // by cnt*DIGIT+j with a fixed wiring.
  always_comb begin
    w_z_next = r_z;
    w_v_next = r_v;
    for (int j = 0; j < DIGIT; j++) begin
      if (r_x[127-j]) w_z_next = w_z_next ^ w_v_next;
      w_v_next = (w_v_next >> 1) ^ (w_v_next[0] ? c_red : 128'd0);
    end
  end

  // Datapath registers
  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      r_x   <= 128'd0;
      r_v   <= 128'd0;
      r_z   <= 128'd0;
      r_cnt <= '0;
    end else if (w_clear) begin
      r_z   <= 128'd0;
    end else if (w_accept) begin
      r_x   <= w_x_load;
      r_v   <= iH;
      r_z   <= 128'd0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_x   <= r_x << DIGIT;
      r_v   <= w_v_next;
      r_z   <= w_z_next;
      r_cnt <= r_cnt + c_cnt_w'(1);
    end
  end

endmodule
`default_nettype wire
